// File: rtl/fcims_pkg.sv
// Shared widths, limits and state encoding for the checkout block.
package fcims_pkg;

    localparam int unsigned PRICE_W   = 8;
    localparam int unsigned TOTAL_W   = 12;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MAX_ITEMS = 15;

    localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_PAY    = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

endpackage

// File: rtl/fcims_accum.sv
// Combinational W-bit add/subtract; flow_c flags carry-out on add or borrow on subtract.
module fcims_accum #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum_c,
    output logic         flow_c
);

    logic [W:0] ext;

    always_comb begin
        ext = '0;
        if (sub) begin
            ext = {1'b0, a} - {1'b0, b};
        end else begin
            ext = {1'b0, a} + {1'b0, b};
        end
        sum_c  = ext[W-1:0];
        flow_c = ext[W];
    end

endmodule

// File: rtl/fcims_checkout.sv
// Checkout controller: accumulates order prices into a bill, takes payment, reports change or refund.
module fcims_checkout
    import fcims_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               item_valid,
    output logic               item_ready,
    input  logic [PRICE_W-1:0] item_price,
    input  logic               item_void,
    input  logic               checkout_req,
    input  logic               pay_valid,
    input  logic [PRICE_W-1:0] pay_amount,
    input  logic               cancel,
    output logic [TOTAL_W-1:0] total,
    output logic [CNT_W-1:0]   item_count,
    output logic [TOTAL_W-1:0] paid,
    output logic               change_valid,
    output logic [TOTAL_W-1:0] change,
    output logic               refund_valid,
    output logic               err,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TOTAL_W-1:0] paid_q, paid_d;
    logic [TOTAL_W-1:0] change_q, change_d;
    logic               change_valid_q, change_valid_d;
    logic               refund_valid_q, refund_valid_d;
    logic               err_q, err_d;
    logic               item_ready_q, item_ready_d;
    logic               busy_q, busy_d;

    logic [TOTAL_W-1:0] bill_sum, pay_sum;
    logic               bill_flow, pay_flow;
    logic               item_hs, item_reject;

    fcims_accum #(.W(TOTAL_W)) u_bill (
        .a      (total_q),
        .b      (TOTAL_W'(item_price)),
        .sub    (item_void),
        .sum_c  (bill_sum),
        .flow_c (bill_flow)
    );

    fcims_accum #(.W(TOTAL_W)) u_paid (
        .a      (paid_q),
        .b      (TOTAL_W'(pay_amount)),
        .sub    (1'b0),
        .sum_c  (pay_sum),
        .flow_c (pay_flow)
    );

    assign item_hs     = item_valid & item_ready_q;
    // A void may not drive the bill negative nor remove an order that was never added.
    assign item_reject = bill_flow | (item_void & (count_q == '0));

    always_comb begin
        state_d        = state_q;
        total_d        = total_q;
        count_d        = count_q;
        paid_d         = paid_q;
        change_d       = change_q;
        change_valid_d = 1'b0;
        refund_valid_d = 1'b0;
        err_d          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                paid_d = '0;
                if (item_hs) begin
                    if (item_reject || item_void) begin
                        err_d = 1'b1;
                    end else begin
                        total_d  = bill_sum;
                        count_d  = count_q + CNT_W'(1);
                        change_d = '0;
                        state_d  = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (cancel) begin
                    total_d = '0;
                    count_d = '0;
                    paid_d  = '0;
                    state_d = ST_IDLE;
                end else if (item_hs) begin
                    if (item_reject) begin
                        err_d = 1'b1;
                    end else begin
                        total_d = bill_sum;
                        count_d = item_void ? count_q - CNT_W'(1) : count_q + CNT_W'(1);
                    end
                end else if (checkout_req && (total_q != '0)) begin
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                // Paid stays visible during the refund pulse; IDLE clears it a cycle later.
                if (cancel) begin
                    total_d        = '0;
                    count_d        = '0;
                    refund_valid_d = 1'b1;
                    state_d        = ST_IDLE;
                end else if (paid_q >= total_q) begin
                    state_d = ST_SETTLE;
                end else if (pay_valid) begin
                    paid_d = pay_flow ? TOTAL_MAX : pay_sum;
                end
            end
            ST_SETTLE: begin
                change_d       = paid_q - total_q;
                change_valid_d = 1'b1;
                total_d        = '0;
                count_d        = '0;
                paid_d         = '0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        item_ready_d = ((state_d == ST_IDLE) || (state_d == ST_SCAN)) &&
                       (count_d < CNT_W'(MAX_ITEMS));
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            total_q        <= '0;
            count_q        <= '0;
            paid_q         <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            refund_valid_q <= 1'b0;
            err_q          <= 1'b0;
            item_ready_q   <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            total_q        <= total_d;
            count_q        <= count_d;
            paid_q         <= paid_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            refund_valid_q <= refund_valid_d;
            err_q          <= err_d;
            item_ready_q   <= item_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign item_ready   = item_ready_q;
    assign total        = total_q;
    assign item_count   = count_q;
    assign paid         = paid_q;
    assign change_valid = change_valid_q;
    assign change       = change_q;
    assign refund_valid = refund_valid_q;
    assign err          = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fcims_checkout.sv
// Directed scenarios plus randomized bills checked against a transaction-level bill/payment model.
module tb_fcims_checkout;
    import fcims_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               item_valid;
    logic               item_ready;
    logic [PRICE_W-1:0] item_price;
    logic               item_void;
    logic               checkout_req;
    logic               pay_valid;
    logic [PRICE_W-1:0] pay_amount;
    logic               cancel;
    logic [TOTAL_W-1:0] total;
    logic [CNT_W-1:0]   item_count;
    logic [TOTAL_W-1:0] paid;
    logic               change_valid;
    logic [TOTAL_W-1:0] change;
    logic               refund_valid;
    logic               err;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Bill model: plain integers for the running bill, order count and tendered amount.
    int m_total;
    int m_cnt;
    int m_paid;

    fcims_checkout dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .item_valid   (item_valid),
        .item_ready   (item_ready),
        .item_price   (item_price),
        .item_void    (item_void),
        .checkout_req (checkout_req),
        .pay_valid    (pay_valid),
        .pay_amount   (pay_amount),
        .cancel       (cancel),
        .total        (total),
        .item_count   (item_count),
        .paid         (paid),
        .change_valid (change_valid),
        .change       (change),
        .refund_valid (refund_valid),
        .err          (err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int price, input bit v);
        item_price = 8'(price);
        item_void  = v;
        item_valid = 1'b1;
        step();
        item_valid = 1'b0;
        item_void  = 1'b0;
    endtask

    task automatic pay(input int amt);
        pay_amount = 8'(amt);
        pay_valid  = 1'b1;
        step();
        pay_valid  = 1'b0;
    endtask

    task automatic do_checkout();
        checkout_req = 1'b1;
        step();
        checkout_req = 1'b0;
    endtask

    // Present one order and compare bill/count/err against the model's arithmetic.
    task automatic model_item(input int price, input bit v);
        bit rej;
        rej = v ? ((price > m_total) || (m_cnt == 0)) : ((m_total + price) > 4095);
        push(price, v);
        if (!rej) begin
            m_total = v ? m_total - price : m_total + price;
            m_cnt   = v ? m_cnt - 1 : m_cnt + 1;
        end
        chk("rnd_err", 32'(err), 32'(rej));
        chk("rnd_total", 32'(total), 32'(m_total));
        chk("rnd_count", 32'(item_count), 32'(m_cnt));
    endtask

    initial begin
        reset_n      = 1'b0;
        item_valid   = 1'b0;
        item_price   = '0;
        item_void    = 1'b0;
        checkout_req = 1'b0;
        pay_valid    = 1'b0;
        pay_amount   = '0;
        cancel       = 1'b0;
        step();
        step();
        chk("rst_total", 32'(total), 0);
        chk("rst_count", 32'(item_count), 0);
        chk("rst_paid", 32'(paid), 0);
        chk("rst_change", 32'(change), 0);
        chk("rst_ready", 32'(item_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pulses", {29'd0, change_valid, refund_valid, err}, 0);
        reset_n = 1'b1;
        step();

        // Basic bill: 24 + 48, pay 50 + 30, change 8.
        push(24, 1'b0);
        chk("b1_total", 32'(total), 24);
        chk("b1_busy", 32'(busy), 1);
        push(48, 1'b0);
        chk("b1_total2", 32'(total), 72);
        chk("b1_count", 32'(item_count), 2);
        do_checkout();
        chk("b1_pay_ready", 32'(item_ready), 0);
        pay(50);
        chk("b1_paid50", 32'(paid), 50);
        pay(30);
        chk("b1_paid80", 32'(paid), 80);
        step();
        chk("b1_cv_early", 32'(change_valid), 0);
        chk("b1_busy_settle", 32'(busy), 1);
        step();
        chk("b1_cv", 32'(change_valid), 1);
        chk("b1_change", 32'(change), 8);
        chk("b1_clr_total", 32'(total), 0);
        chk("b1_clr_paid", 32'(paid), 0);
        chk("b1_clr_count", 32'(item_count), 0);
        chk("b1_idle", 32'(busy), 0);
        step();
        chk("b1_cv_pulse", 32'(change_valid), 0);
        chk("b1_change_held", 32'(change), 8);

        // Void underflow rejected, exact void accepted, zero-total checkout ignored.
        push(72, 1'b0);
        chk("v_change_clr", 32'(change), 0);
        push(100, 1'b1);
        chk("v_err", 32'(err), 1);
        chk("v_total", 32'(total), 72);
        chk("v_count", 32'(item_count), 1);
        push(72, 1'b1);
        chk("v_err_ok", 32'(err), 0);
        chk("v_total0", 32'(total), 0);
        chk("v_count0", 32'(item_count), 0);
        do_checkout();
        chk("v_zero_stays_scan", 32'(item_ready), 1);
        chk("v_zero_busy", 32'(busy), 1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("v_cancel_idle", 32'(busy), 0);
        push(5, 1'b1);
        chk("v_idle_void_err", 32'(err), 1);
        chk("v_idle_void_busy", 32'(busy), 0);

        // Full bill: 15 orders, backpressure without err, checkout while stalled.
        for (int i = 0; i < 15; i++) push(1, 1'b0);
        chk("f_count", 32'(item_count), 15);
        chk("f_ready", 32'(item_ready), 0);
        item_price = 8'd1;
        item_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("f_held_count", 32'(item_count), 15);
            chk("f_held_err", 32'(err), 0);
        end
        item_void = 1'b1;
        step();
        chk("f_void_stall", 32'(total), 15);
        do_checkout();
        item_valid = 1'b0;
        item_void  = 1'b0;
        chk("f_pay_busy", 32'(busy), 1);
        chk("f_pay_total", 32'(total), 15);
        pay(15);
        step();
        step();
        chk("f_cv", 32'(change_valid), 1);
        chk("f_change", 32'(change), 0);

        // Item and checkout in the same cycle: item wins, checkout takes effect next cycle.
        push(10, 1'b0);
        item_price   = 8'd5;
        item_valid   = 1'b1;
        checkout_req = 1'b1;
        step();
        item_valid   = 1'b0;
        chk("s_total", 32'(total), 15);
        chk("s_count", 32'(item_count), 2);
        chk("s_still_scan", 32'(item_ready), 1);
        step();
        checkout_req = 1'b0;
        chk("s_pay", 32'(item_ready), 0);

        // Cancel with a payment in the same cycle: refund shows paid=20, then everything clears.
        pay(20);
        chk("c_paid", 32'(paid), 20);
        cancel     = 1'b1;
        pay_amount = 8'd7;
        pay_valid  = 1'b1;
        step();
        cancel    = 1'b0;
        pay_valid = 1'b0;
        chk("c_refund", 32'(refund_valid), 1);
        chk("c_paid_shown", 32'(paid), 20);
        chk("c_total", 32'(total), 0);
        chk("c_busy", 32'(busy), 0);
        step();
        chk("c_refund_pulse", 32'(refund_valid), 0);
        chk("c_paid_clr", 32'(paid), 0);

        // Asynchronous reset between clock edges while in PAY.
        push(40, 1'b0);
        do_checkout();
        pay(10);
        chk("r_paid", 32'(paid), 10);
        #3;
        reset_n = 1'b0;
        #1;
        chk("r_paid0", 32'(paid), 0);
        chk("r_total0", 32'(total), 0);
        chk("r_count0", 32'(item_count), 0);
        chk("r_busy0", 32'(busy), 0);
        chk("r_ready1", 32'(item_ready), 1);
        #1;
        reset_n = 1'b1;
        step();

        // Randomized bills against the model.
        for (int b = 0; b < 25; b++) begin
            int  nops;
            bit  done;
            m_total = 0;
            m_cnt   = 0;
            m_paid  = 0;
            nops    = $urandom_range(1, 20);
            for (int k = 0; k < nops; k++) begin
                chk("rnd_ready", 32'(item_ready), 32'(m_cnt < 15));
                if (m_cnt < 15) begin
                    model_item($urandom_range(0, 255), ($urandom_range(0, 3) == 0));
                end
            end
            if (m_total == 0) begin
                cancel = 1'b1;
                step();
                cancel = 1'b0;
                chk("rnd_empty_idle", 32'(busy), 0);
                chk("rnd_empty_count", 32'(item_count), 0);
            end else begin
                do_checkout();
                chk("rnd_in_pay", 32'(item_ready), 0);
                done = 1'b0;
                for (int k = 0; k < 200 && !done; k++) begin
                    if ($urandom_range(0, 19) == 0) begin
                        cancel     = 1'b1;
                        pay_valid  = 1'b1;
                        pay_amount = 8'($urandom_range(0, 255));
                        step();
                        cancel     = 1'b0;
                        pay_valid  = 1'b0;
                        chk("rnd_refund", 32'(refund_valid), 1);
                        chk("rnd_refund_paid", 32'(paid), 32'(m_paid));
                        step();
                        chk("rnd_refund_clr", 32'(paid), 0);
                        done = 1'b1;
                    end else begin
                        int amt;
                        amt = $urandom_range(0, 255);
                        pay(amt);
                        m_paid = (m_paid + amt > 4095) ? 4095 : m_paid + amt;
                        chk("rnd_paid", 32'(paid), 32'(m_paid));
                        if (m_paid >= m_total) begin
                            step();
                            chk("rnd_cv_early", 32'(change_valid), 0);
                            step();
                            chk("rnd_cv", 32'(change_valid), 1);
                            chk("rnd_change", 32'(change), 32'(m_paid - m_total));
                            chk("rnd_idle", 32'(busy), 0);
                            done = 1'b1;
                        end
                    end
                end
                chk("rnd_bill_closed", 32'(done), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
